// File: rtl/bcd_hex_display_pkg.sv
// Shared definitions for the BCD seven-segment display stage: FSM states,
// active-low segment patterns {g,f,e,d,c,b,a} and the digit lookup.
package bcd_hex_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;

    // Non-decimal codes render as blank rather than hex glyphs.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_hex_display_seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern.
module seg7_decode
    import bcd_hex_display_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    assign o_seg = bcd_to_seg(i_bcd);

endmodule

// File: rtl/bcd_hex_display.sv
// Sequential double-dabble binary-to-BCD converter driving HEX3..HEX0 with
// sign, divide-by-zero "Err" and leading-zero blanking.
module bcd_hex_display
    import bcd_hex_display_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic             MAX10_CLK1_50,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             is_signed,
    input  logic             err,
    output logic             busy,
    output logic             done,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    // Three digit positions exist on the board; the BCD range must cover the input range.
    if (DIGITS < 1 || DIGITS > 3 || WIDTH < 2 || (10 ** DIGITS) <= (2 ** WIDTH)) begin : g_param_check
        $error("bcd_hex_display: DIGITS/WIDTH combination cannot represent every input");
    end

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_mag;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_neg;
    logic               r_err;

    logic               w_value_neg;
    logic [WIDTH-1:0]   w_value_mag;
    logic [BCD_W-1:0]   w_bcd_adj;
    logic [BCD_W+WIDTH-1:0] w_shift_word;
    logic [6:0]         w_seg  [DIGITS];
    logic [6:0]         w_disp [DIGITS];
    logic [6:0]         w_hex  [3];
    logic [DIGITS:1]    w_higher_nz;

    assign w_value_neg = is_signed & value[WIDTH-1];
    assign w_value_mag = w_value_neg ? ((~value) + {{(WIDTH-1){1'b0}}, 1'b1}) : value;

    genvar gi;

    // Add-3 correction so each nibble carries into the next decade after the shift.
    for (gi = 0; gi < DIGITS; gi++) begin : g_adj
        assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ? (r_bcd[gi*4 +: 4] + 4'd3)
                                                                  : r_bcd[gi*4 +: 4];
    end

    assign w_shift_word = {w_bcd_adj, r_mag} << 1;

    for (gi = 0; gi < DIGITS; gi++) begin : g_dec
        seg7_decode u_seg7_decode (
            .i_bcd (r_bcd[gi*4 +: 4]),
            .o_seg (w_seg[gi])
        );
    end

    // w_higher_nz[d]: digit d or any digit above it is non-zero.
    assign w_higher_nz[DIGITS] = (r_bcd[(DIGITS-1)*4 +: 4] != 4'd0);
    for (gi = 1; gi < DIGITS; gi++) begin : g_nz
        assign w_higher_nz[gi] = w_higher_nz[gi+1] | (r_bcd[(gi-1)*4 +: 4] != 4'd0);
    end

    for (gi = 0; gi < DIGITS; gi++) begin : g_blank
        if (gi == 0) begin : g_units
            assign w_disp[gi] = w_seg[gi];
        end else begin : g_upper
            assign w_disp[gi] = w_higher_nz[gi+1] ? w_seg[gi] : SEG_BLANK;
        end
    end

    for (gi = 0; gi < 3; gi++) begin : g_pad
        if (gi < DIGITS) begin : g_used
            assign w_hex[gi] = w_disp[gi];
        end else begin : g_unused
            assign w_hex[gi] = SEG_BLANK;
        end
    end

    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_mag   <= '0;
            r_bcd   <= '0;
            r_neg   <= 1'b0;
            r_err   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            HEX0    <= SEG_BLANK;
            HEX1    <= SEG_BLANK;
            HEX2    <= SEG_BLANK;
            HEX3    <= SEG_BLANK;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (load) begin
                        busy <= 1'b1;
                        if (err) begin
                            r_err   <= 1'b1;
                            r_neg   <= 1'b0;
                            r_state <= ST_UPDATE;
                        end else begin
                            r_err   <= 1'b0;
                            r_neg   <= w_value_neg;
                            r_mag   <= w_value_mag;
                            r_bcd   <= '0;
                            r_cnt   <= CNT_W'(WIDTH);
                            r_state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    {r_bcd, r_mag} <= w_shift_word;
                    r_cnt          <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    if (r_err) begin
                        HEX3 <= SEG_BLANK;
                        HEX2 <= SEG_E;
                        HEX1 <= SEG_R;
                        HEX0 <= SEG_R;
                    end else begin
                        HEX3 <= r_neg ? SEG_MINUS : SEG_BLANK;
                        HEX2 <= w_hex[2];
                        HEX1 <= w_hex[1];
                        HEX0 <= w_hex[0];
                    end
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_hex_display.sv
// Self-checking bench for bcd_hex_display: directed corner cases plus random
// conversions compared against a decimal-arithmetic reference model.
module tb_bcd_hex_display;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             load;
    logic [WIDTH-1:0] value;
    logic             is_signed;
    logic             err;
    logic             busy;
    logic             done;
    logic [6:0]       HEX0, HEX1, HEX2, HEX3;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    localparam logic [6:0] BLANK = 7'h7F;
    localparam logic [6:0] MINUS = 7'b0111111;
    localparam logic [6:0] LET_E = 7'b0000110;
    localparam logic [6:0] LET_R = 7'b0101111;

    bcd_hex_display #(.WIDTH(WIDTH), .DIGITS(3)) dut (
        .MAX10_CLK1_50 (clk),
        .rst_n         (rst_n),
        .load          (load),
        .value         (value),
        .is_signed     (is_signed),
        .err           (err),
        .busy          (busy),
        .done          (done),
        .HEX0          (HEX0),
        .HEX1          (HEX1),
        .HEX2          (HEX2),
        .HEX3          (HEX3)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference display {HEX3,HEX2,HEX1,HEX0} from decimal arithmetic.
    function automatic logic [27:0] model(input logic [WIDTH-1:0] v, input logic s, input logic e);
        int mag, d0, d1, d2;
        logic neg;
        logic [6:0] h0, h1, h2, h3;
        if (e) return {BLANK, LET_E, LET_R, LET_R};
        neg = s && v[WIDTH-1];
        mag = neg ? (256 - int'(v)) : int'(v);
        d0 = mag % 10;
        d1 = (mag / 10) % 10;
        d2 = mag / 100;
        h0 = seg_tab[d0];
        h1 = (d2 != 0 || d1 != 0) ? seg_tab[d1] : BLANK;
        h2 = (d2 != 0) ? seg_tab[d2] : BLANK;
        h3 = neg ? MINUS : BLANK;
        return {h3, h2, h1, h0};
    endfunction

    function automatic logic [27:0] hex_now();
        return {HEX3, HEX2, HEX1, HEX0};
    endfunction

    // Present load for exactly one edge (edge 0 of the transaction).
    task automatic start(input logic [WIDTH-1:0] v, input logic s, input logic e);
        @(negedge clk);
        load = 1'b1; value = v; is_signed = s; err = e;
        @(posedge clk); #1;
        load = 1'b0; value = WIDTH'($urandom); is_signed = 1'($urandom); err = 1'b0;
    endtask

    task automatic finish_conv(input string tag, input int exp_lat, input logic [27:0] exp_hex,
                               input int start_edge);
        int n;
        n = start_edge;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
        end
        check({tag, " latency"}, n, exp_lat);
        check({tag, " hex"}, hex_now(), exp_hex);
        check({tag, " busy at done"}, busy, 1'b0);
        @(posedge clk); #1;
        check({tag, " done pulse"}, done, 1'b0);
    endtask

    task automatic run_conv(input string tag, input logic [WIDTH-1:0] v, input logic s, input logic e);
        logic [27:0] prev, exp;
        prev = hex_now();
        exp  = model(v, s, e);
        $display("conv %s: value=%02h signed=%0d err=%0d expect=%07h", tag, v, s, e, exp);
        start(v, s, e);
        if (e) begin
            finish_conv(tag, 1, exp, 0);
        end else begin
            @(posedge clk); #1;
            check({tag, " hold"}, hex_now(), prev);
            check({tag, " busy"}, busy, 1'b1);
            finish_conv(tag, WIDTH + 1, exp, 1);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] rv;
        logic rs, re;
        rst_n = 1'b0; load = 1'b0; value = '0; is_signed = 1'b0; err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset hex", hex_now(), {4{BLANK}});
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        run_conv("u42", 8'd42, 1'b0, 1'b0);
        check("u42 digits", {HEX1, HEX0}, {7'b0011001, 7'b0100100});
        run_conv("uFF", 8'hFF, 1'b0, 1'b0);
        run_conv("sFF", 8'hFF, 1'b1, 1'b0);
        run_conv("s80", 8'h80, 1'b1, 1'b0);
        run_conv("zero", 8'd0, 1'b0, 1'b0);
        run_conv("err", 8'd77, 1'b1, 1'b1);
        run_conv("u100", 8'd100, 1'b0, 1'b0);
        run_conv("s7F", 8'h7F, 1'b1, 1'b0);

        // Second load at edge 3 must be ignored.
        $display("conv ignore: value=c8 then load 03 at edge 3");
        start(8'd200, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk); load = 1'b1; value = 8'd3; err = 1'b1;
        @(posedge clk); #1; load = 1'b0; err = 1'b0;
        finish_conv("ignore", WIDTH + 1, model(8'd200, 1'b0, 1'b0), 3);

        // Reset at edge 4 of a conversion discards it.
        $display("conv reset-mid: value=3b, reset at edge 4");
        start(8'd59, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midreset hex", hex_now(), {4{BLANK}});
        check("midreset busy", busy, 1'b0);
        check("midreset done", done, 1'b0);
        @(negedge clk); rst_n = 1'b1;
        run_conv("after reset", 8'd59, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            rv = WIDTH'($urandom);
            rs = 1'($urandom);
            re = ($urandom_range(0, 7) == 0);
            run_conv($sformatf("rand%0d", i), rv, rs, re);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
